motor_speed_ramp: RTL
=====================

Name: motor_speed_ramp

Overview:
- Slew-rate limiter directly upstream of the SPI motor-driver top block; produces its `wdata`/`we` write stream.
- Host or control logic supplies a signed target speed.
- Block moves the commanded speed toward the target by at most RAMP_STEP every UPDATE_PERIOD clocks, issuing one write per change.
- Provides emergency stop and a disable-ramps-to-zero path, so the PMD901 never sees step changes.

Parameters:
- RAMP_STEP, 16'd64: max magnitude change of the commanded speed per update (unsigned, >=1).
- UPDATE_PERIOD, 16'd50000: clk cycles between updates (>=2); at 100 MHz this is a 500 us update interval.
- SPEED_LIMIT, 16'd30000: clamp applied to target magnitude (<=32767).

Ports:
- clk, input, 1: system clock, 100 MHz.
- rst, input, 1: synchronous reset, active-high.
- target_speed, input, 16: signed two's-complement target speed.
- target_valid, input, 1: capture target_speed this cycle.
- enable, input, 1: 0 forces the effective target to 0 (ramped, not stepped).
- estop, input, 1: level; immediate zero speed.
- wdata, output, 16: signed speed word to the SPI block.
- we, output, 1: one-cycle write strobe qualifying wdata.
- current_speed, output, 16: last value written (signed).
- at_target, output, 1: high when in IDLE.

Behaviour:
- Reset (sync, rst=1 at posedge): wdata=0, we=0, current_speed=0, at_target=0, target_reg=0, period counter=0, state=INIT. Applies mid-operation; no further writes until INIT completes.
- Target capture: on target_valid, target_reg <= clamp(target_speed, -SPEED_LIMIT, +SPEED_LIMIT). -32768 clamps to -SPEED_LIMIT. Ignored while state is STOP or estop=1.
- Effective target: eff = enable ? target_reg : 0. target_reg is unchanged by enable.
- Period counter: runs only in RAMP. Cleared on RAMP entry and counts 0..UPDATE_PERIOD-1. tick = (count == UPDATE_PERIOD-1), after which the counter wraps to 0. The first update therefore happens UPDATE_PERIOD cycles after entering RAMP.
- FSM states: INIT, IDLE, RAMP, STOP.
  - INIT:
    - one cycle.
    - Drives we=1, wdata=0 (synchronises the downstream register).
    - Goes to STOP if estop=1, else IDLE.
  - IDLE:
    - at_target=1.
    - If eff != current_speed, go to RAMP next cycle.
  - RAMP, on tick:
    - diff = eff - current_speed, computed in 17-bit signed.
    - If |diff| <= RAMP_STEP, new = eff; else new = current_speed ± RAMP_STEP (sign of diff).
    - current_speed <= new, wdata <= new, we <= 1 for exactly one cycle.
    - If new == eff, go to IDLE; else stay.
    - No write on non-tick cycles.
    - If eff changes mid-ramp, the next tick uses the new eff. Direction reversal through zero is allowed; no special case.
  - STOP:
    - Entered from any non-INIT state the cycle after estop=1 is sampled.
    - On entry: current_speed <= 0, wdata <= 0, we <= 1 for one cycle, regardless of whether current_speed was already 0.
    - Hold while estop=1, with no further writes.
    - On the cycle estop is seen low: target_reg <= 0, go to IDLE. The host must re-issue a target.
- Simultaneous events:
  - estop has priority over tick and target_valid.
  - tick and target_valid together: the tick uses the old target_reg; the new value takes effect from the next cycle.
- Write rate: at most one we per UPDATE_PERIOD cycles, except STOP entry.
- Arithmetic: all comparisons signed. Results never exceed ±SPEED_LIMIT, so there is no overflow.

Decomposition:
- Package motor_ramp_pkg:
  - state enum (INIT, IDLE, RAMP, STOP);
  - SPEED_W=16;
  - a clamp function;
  - a step function (current, eff, step) -> next.
- Sub-module ramp_tick_gen: period counter with clear input and tick output.
- FSM and datapath stay in the top.

Test Plan (use RAMP_STEP=10, UPDATE_PERIOD=4, SPEED_LIMIT=100):
1. Release rst -> one we pulse with wdata=0 on the next cycle, then at_target=1, no further we.
2. target_valid with target_speed=35, enable=1:
   - we pulses every 4 cycles with wdata 10, 20, 30, 35;
   - at_target=1 the cycle after 35 is written.
3. From 35, target_speed=-12:
   - writes 25, 15, 5, -5, -12.
   - Then target_speed=500 is clamped: writes ramp toward 100, and the final write is 100.
4. At speed 40, set enable=0:
   - writes 30, 20, 10, 0.
   - Re-assert enable -> ramps back up to 40.
5. At speed 60 mid-ramp, assert estop:
   - the cycle after it is sampled, we=1 with wdata=0 and current_speed=0;
   - holding estop gives no writes and ignores target_valid;
   - deasserting estop gives IDLE with target_reg=0.
6. Assert rst mid-ramp at speed 50 -> all outputs 0 on the next cycle, then an INIT write of 0, then IDLE.

Source files
------------

// File: rtl/motor_ramp_pkg.sv
// Shared types and arithmetic helpers for the motor speed slew-rate limiter.
package motor_ramp_pkg;

  localparam int unsigned SPEED_W = 16;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RAMP = 2'd2,
    ST_STOP = 2'd3
  } ramp_state_t;

  // Clamp a signed speed into [-limit, +limit]; limit is at most 32767.
  function automatic logic signed [SPEED_W-1:0] speed_clamp(
    input logic signed [SPEED_W-1:0] v,
    input logic        [SPEED_W-1:0] limit
  );
    logic signed [SPEED_W:0] v_x;
    logic signed [SPEED_W:0] lim_x;
    v_x   = {v[SPEED_W-1], v};
    lim_x = {1'b0, limit};
    if (v_x > lim_x)       return $signed(limit);
    else if (v_x < -lim_x) return -$signed(limit);
    else                   return v;
  endfunction

  // Move cur toward eff by at most step, landing exactly on eff when close enough.
  function automatic logic signed [SPEED_W-1:0] ramp_step_next(
    input logic signed [SPEED_W-1:0] cur,
    input logic signed [SPEED_W-1:0] eff,
    input logic        [SPEED_W-1:0] step
  );
    logic signed [SPEED_W:0] diff;
    logic signed [SPEED_W:0] step_x;
    diff   = {eff[SPEED_W-1], eff} - {cur[SPEED_W-1], cur};
    step_x = {1'b0, step};
    if (diff > step_x)       return cur + $signed(step);
    else if (diff < -step_x) return cur - $signed(step);
    else                     return eff;
  endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// Update-period counter: counts 0..PERIOD-1 while not cleared, flags the last count.
module ramp_tick_gen #(
  parameter logic [15:0] PERIOD = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick_c
);

  localparam int unsigned CNT_W = 16;

  logic [CNT_W-1:0] count;

  assign tick_c = !clear && (count == PERIOD - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (tick_c) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/motor_speed_ramp.sv
// Slew-rate limited speed command generator feeding the SPI motor-driver write port.
module motor_speed_ramp
  import motor_ramp_pkg::*;
#(
  parameter logic [15:0] RAMP_STEP     = 16'd64,
  parameter logic [15:0] UPDATE_PERIOD = 16'd50000,
  parameter logic [15:0] SPEED_LIMIT   = 16'd30000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [SPEED_W-1:0] target_speed,
  input  logic                      target_valid,
  input  logic                      enable,
  input  logic                      estop,
  output logic signed [SPEED_W-1:0] wdata,
  output logic                      we,
  output logic signed [SPEED_W-1:0] current_speed,
  output logic                      at_target
);

  ramp_state_t               state, state_nxt;
  logic signed [SPEED_W-1:0] target_reg, target_nxt;
  logic signed [SPEED_W-1:0] speed_nxt, wdata_nxt;
  logic signed [SPEED_W-1:0] eff, step_val;
  logic                      we_nxt;
  logic                      tick_c;

  ramp_tick_gen #(.PERIOD(UPDATE_PERIOD)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != ST_RAMP),
    .tick_c (tick_c)
  );

  // Disable ramps the command to zero without forgetting the host target.
  assign eff      = enable ? target_reg : '0;
  assign step_val = ramp_step_next(current_speed, eff, RAMP_STEP);

  always_comb begin
    state_nxt  = state;
    target_nxt = target_reg;
    speed_nxt  = current_speed;
    wdata_nxt  = wdata;
    we_nxt     = 1'b0;

    if (target_valid && !estop && state != ST_STOP) begin
      target_nxt = speed_clamp(target_speed, SPEED_LIMIT);
    end

    unique case (state)
      ST_INIT: begin
        we_nxt    = 1'b1;
        wdata_nxt = '0;
        state_nxt = estop ? ST_STOP : ST_IDLE;
      end
      ST_IDLE: begin
        if (estop) begin
          state_nxt = ST_STOP;
          speed_nxt = '0;
          wdata_nxt = '0;
          we_nxt    = 1'b1;
        end else if (eff != current_speed) begin
          state_nxt = ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (estop) begin
          state_nxt = ST_STOP;
          speed_nxt = '0;
          wdata_nxt = '0;
          we_nxt    = 1'b1;
        end else if (tick_c) begin
          speed_nxt = step_val;
          wdata_nxt = step_val;
          we_nxt    = 1'b1;
          if (step_val == eff) state_nxt = ST_IDLE;
        end
      end
      ST_STOP: begin
        // Leaving stop forgets the old target so the host must re-arm.
        if (!estop) begin
          target_nxt = '0;
          state_nxt  = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_INIT;
      target_reg    <= '0;
      current_speed <= '0;
      wdata         <= '0;
      we            <= 1'b0;
      at_target     <= 1'b0;
    end else begin
      state         <= state_nxt;
      target_reg    <= target_nxt;
      current_speed <= speed_nxt;
      wdata         <= wdata_nxt;
      we            <= we_nxt;
      at_target     <= (state_nxt == ST_IDLE);
    end
  end

endmodule
